// File: rtl/timer_pkg.sv
// Shared types and constants for the interval timer and its users.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } timer_state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Clock divider: pulses tick once every divisor+1 enabled cycles.
module tick_prescaler #(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] divisor,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;

    // divisor is latched alongside a clear, so cnt_q never overtakes it
    always_comb begin
        tick  = 1'b0;
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == divisor) begin
                tick  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + PRESCALE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/interval_timer.sv
// Programmable interval timer: prescaled counter with one-shot/auto-reload
// modes, pause control and a registered single-cycle expiry pulse.
module interval_timer
    import timer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic                  mode,
    input  logic [WIDTH-1:0]      final_value,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  done
);

    timer_state_t          state_q, state_d;
    logic [WIDTH-1:0]      count_q, count_d;
    logic [WIDTH-1:0]      final_q, final_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  mode_q, mode_d;
    logic                  done_q, done_d;
    logic                  presc_clear, presc_enable, tick;

    // Any control action in a cycle pre-empts counting; PAUSED with pause
    // low counts immediately so a pause costs exactly its own length.
    assign presc_clear  = stop | start;
    assign presc_enable = (state_q != IDLE) & ~stop & ~start & ~pause;

    tick_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (presc_clear),
        .enable  (presc_enable),
        .divisor (prescale_q),
        .tick    (tick)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        final_d    = final_q;
        prescale_d = prescale_q;
        mode_d     = mode_q;
        done_d     = 1'b0;
        if (stop) begin
            state_d = IDLE;
            count_d = '0;
        end else if (start) begin
            state_d    = RUN;
            count_d    = '0;
            final_d    = final_value;
            prescale_d = prescale;
            mode_d     = mode;
        end else if (state_q != IDLE) begin
            if (pause) begin
                state_d = PAUSED;
            end else begin
                state_d = RUN;
                if (tick) begin
                    if (count_q == final_q) begin
                        done_d  = 1'b1;
                        count_d = '0;
                        if (mode_q == MODE_ONESHOT) state_d = IDLE;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            final_q    <= '0;
            prescale_q <= '0;
            mode_q     <= MODE_ONESHOT;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            final_q    <= final_d;
            prescale_q <= prescale_d;
            mode_q     <= mode_d;
            done_q     <= done_d;
        end
    end

    assign count = count_q;
    assign busy  = (state_q != IDLE);
    assign done  = done_q;

endmodule
